pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/proc_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_next.sv | 28 ++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state encoding, defaults and helpers for the program sequencer
package proc_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int START_ADDR_DEF = 0;
    localparam int CYC_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_HALTED  = 3'd4
    } seq_state_t;

    // Run-cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == {CYC_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/memory-side signal bundle of the program sequencer
interface pc_sequencer_if
    import proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic             start;
    logic             branchf;
    logic             branchb;
    logic             halt;
    logic             memread;
    logic             memwrite;
    logic [7:0]       offset;
    logic             mem_ready;
    logic [PC_W-1:0]  pc;
    logic             exec;
    logic             mem_req;
    logic             done;
    logic [CYC_W-1:0] cycles;

    // Controller side: issues start and decoder/memory status, observes sequencing.
    modport master (
        output start, branchf, branchb, halt, memread, memwrite, offset, mem_ready,
        input  pc, exec, mem_req, done, cycles
    );

    // Sequencer side.
    modport slave (
        input  start, branchf, branchb, halt, memread, memwrite, offset, mem_ready,
        output pc, exec, mem_req, done, cycles
    );
endinterface

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC arithmetic, modulo 2^PC_W
module pc_next
    import proc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      offset_i,
    input  logic            branchf_i,
    input  logic            branchb_i,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] offset_ext;

    // Offset is an unsigned distance; forward branch wins when both are taken.
    always_comb begin
        offset_ext = PC_W'(offset_i);
        if (branchf_i) begin
            pc_next_o = pc_i + offset_ext;
        end else if (branchb_i) begin
            pc_next_o = pc_i - offset_ext;
        end else begin
            pc_next_o = pc_i + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute/memory-wait program counter sequencer
module pc_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = START_ADDR_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             branchf_i,
    input  logic             branchb_i,
    input  logic             halt_i,
    input  logic             memread_i,
    input  logic             memwrite_i,
    input  logic [7:0]       offset_i,
    input  logic             mem_ready_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             exec_o,
    output logic             mem_req_o,
    output logic             done_o,
    output logic [CYC_W-1:0] cycles_o
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             exec_q, exec_d;
    logic             mem_req_q, mem_req_d;
    logic             done_q, done_d;
    logic             in_exec;
    logic [PC_W-1:0]  pc_nxt;

    // Branch requests only count in EXEC; in MEMWAIT the adder yields pc+1.
    assign in_exec = (state_q == ST_EXEC);

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc_i      (pc_q),
        .offset_i  (offset_i),
        .branchf_i (branchf_i & in_exec),
        .branchb_i (branchb_i & in_exec),
        .pc_next_o (pc_nxt)
    );

    // Next-state, next-PC and cycle counter; outputs follow the next state so they are registered.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;

        if (state_q == ST_FETCH || state_q == ST_EXEC || state_q == ST_MEMWAIT) begin
            cycles_d = sat_inc(cycles_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_FETCH;
                    pc_d     = START_PC;
                    cycles_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt_i) begin
                    state_d = ST_HALTED;
                end else if (memread_i || memwrite_i) begin
                    state_d = ST_MEMWAIT;
                end else begin
                    pc_d    = pc_nxt;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                if (mem_ready_i) begin
                    pc_d    = pc_nxt;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        exec_d    = (state_d == ST_EXEC);
        mem_req_d = (state_d == ST_MEMWAIT);
        done_d    = (state_d == ST_HALTED);
    end

    // State and output registers; reset acts immediately, even mid-access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            cycles_q  <= '0;
            exec_q    <= 1'b0;
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cycles_q  <= cycles_d;
            exec_q    <= exec_d;
            mem_req_q <= mem_req_d;
            done_q    <= done_d;
        end
    end

    assign pc_o      = pc_q;
    assign exec_o    = exec_q;
    assign mem_req_o = mem_req_q;
    assign done_o    = done_q;
    assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pc_sequencer_if #(.PC_W(10)) bus ();

    pc_sequencer #(
        .PC_W       (10),
        .START_ADDR (0)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .start_i     (bus.start),
        .branchf_i   (bus.branchf),
        .branchb_i   (bus.branchb),
        .halt_i      (bus.halt),
        .memread_i   (bus.memread),
        .memwrite_i  (bus.memwrite),
        .offset_i    (bus.offset),
        .mem_ready_i (bus.mem_ready),
        .pc_o        (bus.pc),
        .exec_o      (bus.exec),
        .mem_req_o   (bus.mem_req),
        .done_o      (bus.done),
        .cycles_o    (bus.cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a FETCH negedge: next negedge is EXEC at exp_pc, decoder inputs are
    // presented for that one cycle, then the following cycle shows exp_after.
    task automatic do_exec(input logic bf, input logic bb, input logic hlt, input logic mr,
                           input logic [7:0] off, input logic [9:0] exp_pc,
                           input logic [9:0] exp_after);
        @(negedge clk);
        chk("exec_pulse", 32'(bus.exec), 32'd1);
        chk("exec_pc", 32'(bus.pc), 32'(exp_pc));
        bus.branchf = bf;
        bus.branchb = bb;
        bus.halt    = hlt;
        bus.memread = mr;
        bus.offset  = off;
        @(negedge clk);
        bus.branchf = 1'b0;
        bus.branchb = 1'b0;
        bus.halt    = 1'b0;
        bus.memread = 1'b0;
        bus.offset  = 8'd0;
        chk("exec_single", 32'(bus.exec), 32'd0);
        chk("pc_after", 32'(bus.pc), 32'(exp_after));
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.branchf   = 1'b0;
        bus.branchb   = 1'b0;
        bus.halt      = 1'b0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.offset    = 8'd0;
        bus.mem_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_exec", 32'(bus.exec), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cycles", 32'(bus.cycles), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_exec", 32'(bus.exec), 32'd0);

        // Start: first FETCH at pc 0
        bus.start = 1'b1;
        @(negedge clk);
        chk("fetch0_pc", 32'(bus.pc), 32'd0);
        chk("fetch0_exec", 32'(bus.exec), 32'd0);
        chk("fetch0_cycles", 32'(bus.cycles), 32'd0);

        // Four plain instructions
        do_exec(0, 0, 0, 0, 8'd0, 10'd0, 10'd1);
        do_exec(0, 0, 0, 0, 8'd0, 10'd1, 10'd2);
        do_exec(0, 0, 0, 0, 8'd0, 10'd2, 10'd3);
        do_exec(0, 0, 0, 0, 8'd0, 10'd3, 10'd4);
        chk("cycles_after4", 32'(bus.cycles), 32'd8);

        // Both branches taken: forward wins
        do_exec(1, 1, 0, 0, 8'd2, 10'd4, 10'd6);
        // Backward by 1
        do_exec(0, 1, 0, 0, 8'd1, 10'd6, 10'd5);

        // Memory read with ready asserted during EXEC (ignored), then 3 wait cycles
        bus.mem_ready = 1'b1;
        do_exec(0, 0, 0, 1, 8'd0, 10'd5, 10'd5);
        bus.mem_ready = 1'b0;
        chk("mw1_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        chk("mw2_req", 32'(bus.mem_req), 32'd1);
        chk("mw2_exec", 32'(bus.exec), 32'd0);
        @(negedge clk);
        chk("mw3_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("mw_done_req", 32'(bus.mem_req), 32'd0);
        chk("mw_done_pc", 32'(bus.pc), 32'd6);

        do_exec(0, 0, 0, 0, 8'd0, 10'd6, 10'd7);
        do_exec(0, 0, 0, 0, 8'd0, 10'd7, 10'd8);
        // Backward wrap below zero
        do_exec(0, 1, 0, 0, 8'd10, 10'd8, 10'd1022);
        do_exec(0, 0, 0, 0, 8'd0, 10'd1022, 10'd1023);
        // Increment wrap
        do_exec(0, 0, 0, 0, 8'd0, 10'd1023, 10'd0);
        do_exec(0, 0, 0, 0, 8'd0, 10'd0, 10'd1);
        do_exec(0, 0, 0, 0, 8'd0, 10'd1, 10'd2);
        do_exec(0, 0, 0, 0, 8'd0, 10'd2, 10'd3);
        // Forward 3 + 5
        do_exec(1, 0, 0, 0, 8'd5, 10'd3, 10'd8);
        do_exec(0, 0, 0, 0, 8'd0, 10'd8, 10'd9);

        // Halt at pc 9 with start held: 18 executes * 2 + 3 wait cycles
        do_exec(0, 0, 1, 0, 8'd0, 10'd9, 10'd9);
        chk("halt_done", 32'(bus.done), 32'd1);
        chk("halt_cycles", 32'(bus.cycles), 32'd39);
        repeat (2) @(negedge clk);
        chk("halt_hold_done", 32'(bus.done), 32'd1);
        chk("halt_hold_pc", 32'(bus.pc), 32'd9);
        chk("halt_hold_cycles", 32'(bus.cycles), 32'd39);
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_pc", 32'(bus.pc), 32'd9);
        @(negedge clk);
        chk("idle_hold_pc", 32'(bus.pc), 32'd9);
        chk("idle_hold_cycles", 32'(bus.cycles), 32'd39);
        bus.start = 1'b1;
        @(negedge clk);
        chk("restart_pc", 32'(bus.pc), 32'd0);
        chk("restart_cycles", 32'(bus.cycles), 32'd0);

        // Reset mid-MEMWAIT
        do_exec(0, 0, 0, 0, 8'd0, 10'd0, 10'd1);
        do_exec(0, 0, 0, 0, 8'd0, 10'd1, 10'd2);
        do_exec(0, 0, 0, 1, 8'd0, 10'd2, 10'd2);
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        chk("pre_rst_cycles", 32'(bus.cycles), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(bus.mem_req), 32'd0);
        chk("async_rst_pc", 32'(bus.pc), 32'd0);
        chk("async_rst_cycles", 32'(bus.cycles), 32'd0);
        chk("async_rst_exec", 32'(bus.exec), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_held_req", 32'(bus.mem_req), 32'd0);
        rst = 1'b0;
        // start still high: sampled on the first edge after release
        @(negedge clk);
        chk("post_rst_fetch_exec", 32'(bus.exec), 32'd0);
        chk("post_rst_fetch_pc", 32'(bus.pc), 32'd0);
        @(negedge clk);
        chk("post_rst_exec", 32'(bus.exec), 32'd1);
        chk("post_rst_cycles", 32'(bus.cycles), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
